la_pwrseq: RTL

//  Power-switch sequencer for one switchable power domain. It drives a

---
 rtl/la_pwrseq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/la_pwrseq.sv
// Power-switch sequencer for one switchable domain: staggered segment enables,
// isolation/reset sequencing around transitions, and a bounded power-good check.
module la_pwrseq #(
  parameter int N   = 4,
  parameter int DLY = 8,
  parameter int TMO = 64
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         req,
  input  logic         pwr_ok,
  output logic [N-1:0] sw_en,
  output logic         iso_en,
  output logic         dom_nreset,
  output logic         on,
  output logic         busy,
  output logic         err
);

  localparam int CMAX = (DLY > TMO) ? DLY : TMO;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DLY_END = CW'(DLY - 1);
  localparam logic [CW-1:0] TMO_END = CW'(TMO - 1);
  localparam logic [N-1:0]  SW_ALL  = '1;

  typedef enum logic [3:0] {
    S_OFF, S_UP, S_WAIT_PG, S_UNISO, S_UNRST,
    S_ON, S_DN_ISO, S_DN_RST, S_DN_SW, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sw_d;
  logic          iso_d, nrst_d, on_d, busy_d, err_d;
  logic          pg_meta, pg_s;
  logic          step_done;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pg_meta    <= 1'b0;
      pg_s       <= 1'b0;
      state_q    <= S_OFF;
      cnt_q      <= '0;
      sw_en      <= '0;
      iso_en     <= 1'b1;
      dom_nreset <= 1'b0;
      on         <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      pg_meta    <= pwr_ok;
      pg_s       <= pg_meta;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sw_en      <= sw_d;
      iso_en     <= iso_d;
      dom_nreset <= nrst_d;
      on         <= on_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

  assign step_done = (cnt_q == DLY_END);

  // Outputs are computed from the next state so every output is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_en;
    iso_d   = iso_en;
    nrst_d  = dom_nreset;
    on_d    = on;
    err_d   = err;
    case (state_q)
      S_OFF: begin
        if (req) begin
          state_d = S_UP;
          cnt_d   = '0;
          sw_d    = N'(1);
        end
      end
      S_UP: begin
        if (step_done) begin
          cnt_d = '0;
          if (sw_en == SW_ALL) state_d = S_WAIT_PG;
          else                 sw_d    = (sw_en << 1) | N'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_PG: begin
        if (pg_s) begin
          state_d = S_UNISO;
          cnt_d   = '0;
          iso_d   = 1'b0;
        end else if (cnt_q == TMO_END) begin
          state_d = S_ERR;
          cnt_d   = '0;
          sw_d    = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UNISO: begin
        if (step_done) begin
          state_d = S_UNRST;
          cnt_d   = '0;
          nrst_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UNRST: begin
        if (step_done) begin
          state_d = S_ON;
          cnt_d   = '0;
          on_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ON: begin
        // Brownout outranks a power-down request.
        if (!pg_s) begin
          state_d = S_ERR;
          sw_d    = '0;
          iso_d   = 1'b1;
          nrst_d  = 1'b0;
          on_d    = 1'b0;
          err_d   = 1'b1;
        end else if (!req) begin
          state_d = S_DN_ISO;
          cnt_d   = '0;
          on_d    = 1'b0;
          iso_d   = 1'b1;
        end
      end
      S_DN_ISO: begin
        if (step_done) begin
          state_d = S_DN_RST;
          cnt_d   = '0;
          nrst_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DN_RST: begin
        if (step_done) begin
          state_d = S_DN_SW;
          cnt_d   = '0;
          sw_d    = sw_en >> 1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DN_SW: begin
        if (step_done) begin
          cnt_d = '0;
          if (sw_en == '0) state_d = S_OFF;
          else             sw_d    = sw_en >> 1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERR: begin
        if (!req) begin
          state_d = S_OFF;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_OFF;
    endcase
    busy_d = !(state_d inside {S_OFF, S_ON, S_ERR});
  end

endmodule
